// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the cpu_run_ctrl host sequencer: job state encoding,
// memory address steps and the empty-stage skip helper.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, LD_IMEM, LD_DMEM, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, FIN
  } state_t;

  localparam logic [63:0] IMEM_STEP = 64'd4;
  localparam logic [63:0] DMEM_STEP = 64'd8;

  // Walks forward from a candidate stage past any stage with nothing to do.
  function automatic state_t skip_empty(state_t s, logic imem_nz, logic dmem_nz, logic run_nz);
    state_t t;
    t = s;
    if (t == LD_IMEM && !imem_nz) t = LD_DMEM;
    if (t == LD_DMEM && !dmem_nz) t = RUN;
    if (t == RUN && !run_nz) t = DUMP_RD;
    if (t == DUMP_RD && !dmem_nz) t = FIN;
    return t;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_dump.sv
// DMEM dump engine: read strobe, capture of the returned word and the held
// output register presented to the host until it is accepted.
module cpu_run_ctrl_dump
  import cpu_run_ctrl_pkg::*;
#(
  parameter int IDX_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  state_t           state,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      rdata,
  input  logic             dump_ready,
  output logic             ren,
  output logic [63:0]      raddr,
  output logic             dump_valid,
  output logic [63:0]      dump_data,
  output logic             hs
);

  assign ren        = (state == DUMP_RD);
  assign raddr      = ren ? 64'(idx) * DMEM_STEP : '0;
  assign dump_valid = (state == DUMP_OUT);
  assign hs         = dump_valid & dump_ready;

  // Memory returns data the cycle after the read strobe, i.e. in DUMP_CAP.
  always_ff @(posedge clk) begin
    if (rst)                    dump_data <= '0;
    else if (state == DUMP_CAP) dump_data <= rdata;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side job sequencer for the 5-stage core: load IMEM, load DMEM, run,
// dump DMEM. Optional halt detection with CPU_RUN_CTRL_HALT_DETECT_EN.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       imem_words,
  input  logic [10:0]      dmem_words,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [63:0]      ld_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [63:0]      dump_data,
  output logic             busy,
  output logic             done,
  output logic             cpu_enable,
  output logic             cpu_arst_n,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2
`ifdef CPU_RUN_CTRL_HALT_DETECT_EN
  ,
  input  logic             halt_in,
  output logic [CNT_W-1:0] cycles_used
`endif
);

  localparam int IDX_W = 11;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx, idx_inc, imem_n, dmem_n, stage_n;
  logic [IDX_W-1:0] imem_clamp, dmem_clamp;
  logic [CNT_W-1:0] cnt;
  logic             ld_fire, dump_hs, last, halt;
  logic [63:0]      dump_addr;

`ifdef CPU_RUN_CTRL_HALT_DETECT_EN
  assign halt = halt_in;
`else
  assign halt = 1'b0;
`endif

  assign imem_clamp = ({1'b0, imem_words} > IDX_W'(IMEM_DEPTH)) ? IDX_W'(IMEM_DEPTH) : {1'b0, imem_words};
  assign dmem_clamp = (dmem_words > IDX_W'(DMEM_DEPTH)) ? IDX_W'(DMEM_DEPTH) : dmem_words;

  assign ld_ready = (state_q == LD_IMEM) || (state_q == LD_DMEM);
  assign ld_fire  = ld_valid & ld_ready;
  assign idx_inc  = idx + IDX_W'(1);
  assign stage_n  = (state_q == LD_IMEM) ? imem_n : dmem_n;
  assign last     = (idx_inc == stage_n);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = skip_empty(LD_IMEM, imem_clamp != '0, dmem_clamp != '0, run_cycles != '0);
      LD_IMEM:  if (ld_fire && last) state_d = skip_empty(LD_DMEM, 1'b1, dmem_n != '0, cnt != '0);
      LD_DMEM:  if (ld_fire && last) state_d = skip_empty(RUN, 1'b1, 1'b1, cnt != '0);
      RUN:      if (cnt == CNT_W'(1) || halt) state_d = skip_empty(DUMP_RD, 1'b1, dmem_n != '0, 1'b1);
      DUMP_RD:  state_d = DUMP_CAP;
      DUMP_CAP: state_d = DUMP_OUT;
      DUMP_OUT: if (dump_hs) state_d = last ? FIN : DUMP_RD;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx     <= '0;
      imem_n  <= '0;
      dmem_n  <= '0;
      cnt     <= '0;
`ifdef CPU_RUN_CTRL_HALT_DETECT_EN
      cycles_used <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        imem_n <= imem_clamp;
        dmem_n <= dmem_clamp;
        cnt    <= run_cycles;
        idx    <= '0;
`ifdef CPU_RUN_CTRL_HALT_DETECT_EN
        cycles_used <= '0;
`endif
      end
      // idx is shared by all three streaming stages; clearing it on the
      // final word hands the next stage a fresh index.
      if (ld_fire || dump_hs) idx <= last ? '0 : idx_inc;
      if (state_q == RUN) begin
        cnt <= cnt - CNT_W'(1);
`ifdef CPU_RUN_CTRL_HALT_DETECT_EN
        cycles_used <= cycles_used + CNT_W'(1);
`endif
      end
    end
  end

  cpu_run_ctrl_dump #(.IDX_W(IDX_W)) u_dump (
    .clk        (clk),
    .rst        (rst),
    .state      (state_q),
    .idx        (idx),
    .rdata      (rdata_ext_2),
    .dump_ready (dump_ready),
    .ren        (ren_ext_2),
    .raddr      (dump_addr),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .hs         (dump_hs)
  );

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign cpu_enable = (state_q == RUN);
  assign cpu_arst_n = (state_q == RUN);

  assign wen_ext     = (state_q == LD_IMEM) & ld_valid;
  assign ren_ext     = 1'b0;
  assign addr_ext    = (state_q == LD_IMEM) ? 64'(idx) * IMEM_STEP : '0;
  assign wdata_ext   = (state_q == LD_IMEM) ? ld_data[31:0] : '0;
  assign wen_ext_2   = (state_q == LD_DMEM) & ld_valid;
  assign addr_ext_2  = (state_q == LD_DMEM) ? 64'(idx) * DMEM_STEP : dump_addr;
  assign wdata_ext_2 = (state_q == LD_DMEM) ? ld_data : '0;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Host-side sequencer for the 5-stage RISC-V core (`cpu`).
- Drives the core's external IMEM/DMEM ports and its `enable`/`arst_n` pins.
- Sequence per job: stream-load a program into instruction memory, stream-load initial data into data memory, run the core for a programmed number of cycles, then stream the data memory contents back to the host.
- Sits between the testbench/host link and `cpu`; it is the only agent driving the `*_ext` and `*_ext_2` ports.

Parameters:
- IMEM_DEPTH, 512, instruction memory depth in 32-bit words (word address step 4).
- DMEM_DEPTH, 1024, data memory depth in 64-bit words (word address step 8).
- CNT_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a job when idle
- imem_words  in  10  words to load into IMEM (0..IMEM_DEPTH)
- dmem_words  in  11  words to load into and dump from DMEM (0..DMEM_DEPTH)
- run_cycles  in  CNT_W  cycles to hold cpu_enable high
- ld_valid  in  1  load word valid
- ld_ready  out  1  load word accepted
- ld_data  in  64  load word; IMEM uses [31:0]
- dump_valid  out  1  dump word valid
- dump_ready  in  1  host accepts dump word
- dump_data  out  64  dump word
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- cpu_enable  out  1  to cpu enable
- cpu_arst_n  out  1  to cpu arst_n
- addr_ext  out  64  IMEM external address
- wen_ext  out  1  IMEM external write enable
- ren_ext  out  1  IMEM external read enable (tied 0)
- wdata_ext  out  32  IMEM external write data
- addr_ext_2  out  64  DMEM external address
- wen_ext_2  out  1  DMEM external write enable
- ren_ext_2  out  1  DMEM external read enable
- wdata_ext_2  out  64  DMEM external write data
- rdata_ext_2  in  64  DMEM external read data, valid 1 cycle after ren_ext_2
- halt_in  in  1  core halt indication (present only with HALT_DETECT_EN)

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - State goes to IDLE; all counters cleared.
  - cpu_arst_n=0; all other outputs 0.
  - Reset mid-job abandons the job with no done pulse.
- Job parameters: imem_words, dmem_words and run_cycles are latched on an accepted start. Values above the depth are clamped to the depth.
- start is ignored while busy=1. busy=1 in every state except IDLE.
- cpu_arst_n=1 only in RUN; 0 in every other state. This keeps the pipeline flushed, so the core issues no DMEM writes while the controller owns the ports.
- IDLE → LD_IMEM on start.
  - Zero-count states are skipped: LD_IMEM when imem_words=0, LD_DMEM and DUMP when dmem_words=0, RUN when run_cycles=0.
- LD_IMEM:
  - ld_ready=1.
  - On ld_valid&ld_ready, in the same cycle: wen_ext=1, addr_ext=4*idx, wdata_ext=ld_data[31:0]; idx++.
  - After the last word → LD_DMEM; idx is cleared.
- LD_DMEM: same handshake; wen_ext_2=1, addr_ext_2=8*idx, wdata_ext_2=ld_data. After the last word → RUN.
  - ld_ready=0 in all other states; a ld_valid stall inserts no write.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles; the counter decrements each cycle.
  - Exit at count 1 → DUMP_RD.
- Dump loop, 3 cycles minimum per word:
  - DUMP_RD: ren_ext_2=1, addr_ext_2=8*idx.
  - DUMP_CAP: capture rdata_ext_2 into dump_data.
  - DUMP_OUT: dump_valid=1 with dump_data held stable until dump_ready. On the handshake, idx++; then → DUMP_RD, or → FIN after the last word.
- FIN: done=1 for one cycle → IDLE.
- Address arithmetic: idx is unsigned and zero-extended to 64 bits before scaling. There is no wrap, because counts are clamped.

Optional Feature:
- Macro: CPU_RUN_CTRL_HALT_DETECT_EN.
- When defined:
  - The halt_in port exists.
  - halt_in=1 in RUN ends RUN that cycle; cpu_enable is 0 from the next cycle and the state goes to DUMP_RD.
  - Output cycles_used (CNT_W) holds the number of enabled cycles. It is valid from FIN until the next start and cleared on reset.
- When undefined: no halt_in or cycles_used ports; RUN always lasts exactly run_cycles.

Decomposition:
- Package cpu_run_ctrl_pkg holds:
  - the state enum (IDLE, LD_IMEM, LD_DMEM, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, FIN);
  - IMEM_STEP=4 and DMEM_STEP=8.
- One natural sub-module: cpu_run_ctrl_dump, the 3-state read/capture/handshake engine with its output register.

Test Plan:
- imem_words=3, dmem_words=2, run_cycles=5, ld_valid always 1 → IMEM writes at addresses 0,4,8, then DMEM writes at 0,8; cpu_enable high exactly 5 cycles; dump returns the DMEM contents as seen through the memory model; done pulses once.
- ld_valid toggling 1,0,1,0 → write enables fire only on valid cycles; addresses remain contiguous.
- dump_ready held 0 for 4 cycles in DUMP_OUT → dump_valid and dump_data stay stable; no extra ren_ext_2 is issued.
- imem_words=0, dmem_words=0, run_cycles=0 → IDLE to FIN in 1 cycle; busy high for 1 cycle; done pulses.
- rst asserted mid-RUN → next cycle: cpu_enable=0, cpu_arst_n=0, busy=0, no done; a new start runs a full job.
- With HALT_DETECT_EN: run_cycles=100, halt_in raised on the 7th RUN cycle → cpu_enable low from the 8th cycle; cycles_used=7.
